// File: rtl/wb_timer.sv
// wb_timer: Wishbone classic slave timer/counter with a prescaler, compare
// match and a level interrupt.
//
// Ports:
//   clk_i      core clock
//   rst_ni     asynchronous active-low reset
//   addr_i     byte address; only bits [4:2] select a register
//   data_i     write data
//   data_o     read data, non-zero only while ack_o=1
//   wr_en_i    1=write, 0=read
//   byte_en_i  byte enables; bit n covers data bits [8n+7:8n]
//   stb_i      strobe
//   cyc_i      cycle
//   ack_o      single-cycle acknowledge, always followed by a low cycle
//   irq_o      STATUS.match & CTRL.irq_en
//
// Register map (addr_i[4:2]):
//   0 CTRL     [0] enable [1] irq_en [2] auto_reload [3] one_shot
//   1 COUNT    RW
//   2 COMPARE  RW
//   3 STATUS   [0] match, write-1-to-clear
//   4 PRESCALE [PRESC_WIDTH-1:0] RW
//   5-7        read 0, writes ignored
module wb_timer #(
    parameter int          PRESC_WIDTH   = 16,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        wr_en_i,
    input  logic [3:0]  byte_en_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        irq_o
);

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_COUNT    = 3'd1;
    localparam logic [2:0] A_COMPARE  = 3'd2;
    localparam logic [2:0] A_STATUS   = 3'd3;
    localparam logic [2:0] A_PRESCALE = 3'd4;

    // Replace only the bytes whose enable is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic                   ack_r;
    logic [31:0]            data_r;
    logic [3:0]             ctrl_r;
    logic [31:0]            count_r;
    logic [31:0]            compare_r;
    logic                   status_r;
    logic [PRESC_WIDTH-1:0] prescale_r;
    logic [PRESC_WIDTH-1:0] presc_cnt_r;

    logic                   req_s;
    logic                   wr_ctrl_s;
    logic                   wr_count_s;
    logic                   wr_compare_s;
    logic                   wr_status_s;
    logic                   wr_prescale_s;
    logic [31:0]            ctrl_merged_s;
    logic [31:0]            count_merged_s;
    logic [31:0]            compare_merged_s;
    logic [31:0]            prescale_merged_s;
    logic [31:0]            prescale_ext_s;
    logic                   tick_s;
    logic                   match_s;
    logic [31:0]            rd_data_s;
    logic [31:0]            data_nxt_s;
    logic [3:0]             ctrl_nxt_s;
    logic [31:0]            count_nxt_s;
    logic                   status_nxt_s;
    logic [PRESC_WIDTH-1:0] presc_cnt_nxt_s;
    logic                   unused_s;

    // Bus decode, tick/match detection and read mux.
    always_comb begin
        req_s         = cyc_i & stb_i & ~ack_r;
        wr_ctrl_s     = req_s & wr_en_i & (addr_i[4:2] == A_CTRL);
        wr_count_s    = req_s & wr_en_i & (addr_i[4:2] == A_COUNT);
        wr_compare_s  = req_s & wr_en_i & (addr_i[4:2] == A_COMPARE);
        wr_status_s   = req_s & wr_en_i & (addr_i[4:2] == A_STATUS);
        wr_prescale_s = req_s & wr_en_i & (addr_i[4:2] == A_PRESCALE);

        prescale_ext_s = 32'd0;
        prescale_ext_s[PRESC_WIDTH-1:0] = prescale_r;

        ctrl_merged_s     = merge_bytes({28'd0, ctrl_r}, data_i, byte_en_i);
        count_merged_s    = merge_bytes(count_r, data_i, byte_en_i);
        compare_merged_s  = merge_bytes(compare_r, data_i, byte_en_i);
        prescale_merged_s = merge_bytes(prescale_ext_s, data_i, byte_en_i);

        tick_s  = ctrl_r[0] & (presc_cnt_r == prescale_r);
        // A software COUNT write on a tick edge suppresses the compare.
        match_s = tick_s & ~wr_count_s & (count_r == compare_r);

        case (addr_i[4:2])
            A_CTRL:     rd_data_s = {28'd0, ctrl_r};
            A_COUNT:    rd_data_s = count_r;
            A_COMPARE:  rd_data_s = compare_r;
            A_STATUS:   rd_data_s = {31'd0, status_r};
            A_PRESCALE: rd_data_s = prescale_ext_s;
            default:    rd_data_s = 32'd0;
        endcase

        if (req_s & ~wr_en_i) begin
            data_nxt_s = rd_data_s;
        end else begin
            data_nxt_s = 32'd0;
        end
    end

    // Next-state of the timer registers, resolving same-edge collisions.
    always_comb begin
        // CTRL: software write beats the one_shot auto-clear.
        if (wr_ctrl_s) begin
            ctrl_nxt_s = ctrl_merged_s[3:0];
        end else if (match_s & ctrl_r[3]) begin
            ctrl_nxt_s = {ctrl_r[3:1], 1'b0};
        end else begin
            ctrl_nxt_s = ctrl_r;
        end

        // COUNT: software write beats the tick.
        if (wr_count_s) begin
            count_nxt_s = count_merged_s;
        end else if (match_s & ctrl_r[2]) begin
            count_nxt_s = 32'd0;
        end else if (tick_s) begin
            count_nxt_s = count_r + 32'd1;
        end else begin
            count_nxt_s = count_r;
        end

        // STATUS: a hardware match beats the W1C.
        if (match_s) begin
            status_nxt_s = 1'b1;
        end else if (wr_status_s & byte_en_i[0] & data_i[0]) begin
            status_nxt_s = 1'b0;
        end else begin
            status_nxt_s = status_r;
        end

        // Prescaler restarts when the timer is switched on.
        if (wr_ctrl_s & ctrl_merged_s[0] & ~ctrl_r[0]) begin
            presc_cnt_nxt_s = '0;
        end else if (tick_s) begin
            presc_cnt_nxt_s = '0;
        end else if (ctrl_r[0]) begin
            presc_cnt_nxt_s = presc_cnt_r + PRESC_WIDTH'(1);
        end else begin
            presc_cnt_nxt_s = presc_cnt_r;
        end
    end

    // Bus handshake registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_r  <= 1'b0;
            data_r <= 32'd0;
        end else begin
            ack_r  <= req_s;
            data_r <= data_nxt_s;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_r      <= 4'd0;
            count_r     <= 32'd0;
            compare_r   <= RESET_COMPARE;
            status_r    <= 1'b0;
            prescale_r  <= '0;
            presc_cnt_r <= '0;
        end else begin
            ctrl_r      <= ctrl_nxt_s;
            count_r     <= count_nxt_s;
            status_r    <= status_nxt_s;
            presc_cnt_r <= presc_cnt_nxt_s;
            if (wr_compare_s) begin
                compare_r <= compare_merged_s;
            end
            if (wr_prescale_s) begin
                prescale_r <= prescale_merged_s[PRESC_WIDTH-1:0];
            end
        end
    end

    assign ack_o  = ack_r;
    assign data_o = data_r;
    assign irq_o  = status_r & ctrl_r[1];

    // Address bits decoded upstream and merge bits with no storage behind them.
    assign unused_s = ^{addr_i[31:5], addr_i[1:0], ctrl_merged_s[31:4],
                        prescale_merged_s[31:PRESC_WIDTH]};

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: a table of bus accesses with expected
// read data (scoreboarded through a queue until ack_o), plus hand-written
// handshake and reset sequences.
module tb_wb_timer;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    logic [3:0]  be;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
        logic        ci;
        logic        irq;
    } vec_t;

    vec_t vecs[$];

    wb_timer dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .addr_i    (addr),
        .data_i    (wdata),
        .data_o    (rdata),
        .wr_en_i   (we),
        .byte_en_i (be),
        .stb_i     (stb),
        .cyc_i     (cyc),
        .ack_o     (ack),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] R_CTRL  = 32'h00;
    localparam logic [31:0] R_COUNT = 32'h04;
    localparam logic [31:0] R_CMP   = 32'h08;
    localparam logic [31:0] R_STAT  = 32'h0C;
    localparam logic [31:0] R_PRESC = 32'h10;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void add_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        vec_t v;
        v = '{we: 1'b1, addr: a, data: d, be: b, exp: 32'd0, ci: 1'b0, irq: 1'b0};
        vecs.push_back(v);
    endfunction

    function automatic void add_rd(input logic [31:0] a, input logic [31:0] e, input logic c, input logic i);
        vec_t v;
        v = '{we: 1'b0, addr: a, data: 32'd0, be: 4'hF, exp: e, ci: c, irq: i};
        vecs.push_back(v);
    endfunction

    // One access: drive on a negedge, then wait (bounded) for ack_o and
    // pop the expected read data from the scoreboard.
    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, input logic [31:0] e, input string nm);
        int          n;
        logic [31:0] qe;
        string       qn;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; be = b;
        if (!w) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 4);
        check({nm, "_ack_lat"}, {31'd0, ack} + 32'(n), 32'd2);
        if (!w) begin
            qe = exp_q.pop_front();
            qn = name_q.pop_front();
            check(qn, rdata, qe);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; wdata = 32'd0; be = 4'h0;
    endtask

    initial begin
        cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'h0;
        rst_n = 1'b0;

        // Reset values
        add_rd(R_CTRL,  32'd0, 1'b1, 1'b0);
        add_rd(R_COUNT, 32'd0, 1'b0, 1'b0);
        add_rd(R_CMP,   32'hFFFF_FFFF, 1'b0, 1'b0);
        add_rd(R_STAT,  32'd0, 1'b0, 1'b0);
        add_rd(R_PRESC, 32'd0, 1'b0, 1'b0);
        // Periodic match: one table row commits every second edge
        add_wr(R_PRESC, 32'd0, 4'hF);
        add_wr(R_CMP,   32'd5, 4'hF);
        add_wr(R_COUNT, 32'd0, 4'hF);
        add_wr(R_CTRL,  32'h7, 4'hF);
        add_rd(R_COUNT, 32'd1, 1'b0, 1'b0);
        add_rd(R_COUNT, 32'd3, 1'b1, 1'b0);
        add_rd(R_COUNT, 32'd5, 1'b1, 1'b1);
        add_rd(R_COUNT, 32'd1, 1'b0, 1'b0);
        add_rd(R_STAT,  32'd1, 1'b1, 1'b1);
        add_wr(R_STAT,  32'd1, 4'hF);
        add_rd(R_STAT,  32'd1, 1'b1, 1'b1);
        add_wr(R_STAT,  32'd1, 4'hF);
        vecs[vecs.size()-1].ci  = 1'b1;
        vecs[vecs.size()-1].irq = 1'b0;
        add_rd(R_STAT,  32'd0, 1'b0, 1'b0);
        add_wr(R_CTRL,  32'h0, 4'hF);
        vecs[vecs.size()-1].ci  = 1'b1;
        add_rd(R_COUNT, 32'd2, 1'b0, 1'b0);
        add_wr(R_STAT,  32'd1, 4'hF);
        add_rd(R_STAT,  32'd0, 1'b0, 1'b0);
        // Prescaler plus one_shot
        add_wr(R_PRESC, 32'd3, 4'hF);
        add_wr(R_CMP,   32'd2, 4'hF);
        add_wr(R_COUNT, 32'd0, 4'hF);
        add_wr(R_CTRL,  32'h9, 4'hF);
        add_rd(R_COUNT, 32'd0, 1'b0, 1'b0);
        add_rd(R_COUNT, 32'd0, 1'b0, 1'b0);
        add_rd(R_COUNT, 32'd1, 1'b0, 1'b0);
        add_rd(R_COUNT, 32'd1, 1'b0, 1'b0);
        add_rd(R_COUNT, 32'd2, 1'b0, 1'b0);
        add_rd(R_COUNT, 32'd2, 1'b0, 1'b0);
        add_rd(R_COUNT, 32'd3, 1'b0, 1'b0);
        add_rd(R_CTRL,  32'h8, 1'b0, 1'b0);
        add_rd(R_COUNT, 32'd3, 1'b0, 1'b0);
        add_rd(R_STAT,  32'd1, 1'b1, 1'b0);
        add_wr(R_STAT,  32'd1, 4'hF);
        // COUNT write colliding with a tick (and a would-be match)
        add_wr(R_CMP,   32'd0, 4'hF);
        add_wr(R_COUNT, 32'd0, 4'hF);
        add_wr(R_CTRL,  32'h1, 4'hF);
        add_rd(R_STAT,  32'd0, 1'b0, 1'b0);
        add_wr(R_COUNT, 32'd100, 4'hF);
        add_rd(R_COUNT, 32'd100, 1'b0, 1'b0);
        add_rd(R_COUNT, 32'd100, 1'b0, 1'b0);
        add_rd(R_COUNT, 32'd101, 1'b0, 1'b0);
        add_rd(R_STAT,  32'd0, 1'b0, 1'b0);
        add_wr(R_CTRL,  32'h0, 4'hF);
        // Byte enables, masks, unmapped offsets
        add_wr(R_CMP,   32'd0, 4'hF);
        add_wr(R_CMP,   32'hAABB_CCDD, 4'b0101);
        add_rd(R_CMP,   32'h00BB_00DD, 1'b0, 1'b0);
        add_wr(R_COUNT, 32'h1234_5678, 4'b0000);
        add_rd(R_COUNT, 32'd102, 1'b0, 1'b0);
        add_wr(R_CTRL,  32'hFFFF_FFF0, 4'hF);
        add_rd(R_CTRL,  32'd0, 1'b0, 1'b0);
        add_wr(R_PRESC, 32'hFFFF_FFFF, 4'hF);
        add_rd(R_PRESC, 32'h0000_FFFF, 1'b0, 1'b0);
        add_wr(32'h18,  32'hDEAD_BEEF, 4'hF);
        add_rd(32'h18,  32'd0, 1'b0, 1'b0);
        add_rd(32'h14,  32'd0, 1'b0, 1'b0);
        add_wr(R_PRESC, 32'd0, 4'b0011);
        add_rd(R_PRESC, 32'd0, 1'b0, 1'b0);

        // Outputs quiet while held in reset
        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_data", rdata, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            do_access(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].exp,
                      $sformatf("vec%0d", i));
            if (vecs[i].ci) begin
                check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].irq});
            end
        end

        // Held strobe on an unmapped offset: ack 1,0,1,0 with data 0
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h1C; be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("hold_ack%0d", k), {31'd0, ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("hold_data%0d", k), rdata, 32'd0);
        end
        stb = 1'b0; cyc = 1'b0;

        // Strobe without cycle is ignored
        @(negedge clk);
        stb = 1'b1; cyc = 1'b0; addr = R_COUNT;
        repeat (2) @(negedge clk);
        check("nocyc_ack", {31'd0, ack}, 32'd0);
        stb = 1'b0;

        // Build an interrupt, then reset in the middle of an ack
        do_access(1'b1, R_COUNT, 32'd0, 4'hF, 32'd0, "pre_cnt");
        do_access(1'b1, R_CMP,   32'd0, 4'hF, 32'd0, "pre_cmp");
        do_access(1'b1, R_CTRL,  32'h3, 4'hF, 32'd0, "pre_ctrl");
        @(negedge clk);
        check("pre_irq", {31'd0, irq}, 32'd1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = R_COUNT; be = 4'hF;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ack", {31'd0, ack}, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        check("midrst_data", rdata, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_access(1'b0, R_CTRL,  32'd0, 4'hF, 32'd0, "post_ctrl");
        do_access(1'b0, R_COUNT, 32'd0, 4'hF, 32'd0, "post_count");
        do_access(1'b0, R_CMP,   32'd0, 4'hF, 32'hFFFF_FFFF, "post_cmp");
        do_access(1'b0, R_STAT,  32'd0, 4'hF, 32'd0, "post_stat");
        do_access(1'b0, R_PRESC, 32'd0, 4'hF, 32'd0, "post_presc");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
